// File: rtl/am2950_chan.sv
// am2950_chan: one channel of the bidirectional port. Holds one data register
// with its "register full" flag and sticky overrun bit, and drives the
// register onto a tri-state output.
module am2950_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             le_,
    input  logic             clr_,
    input  logic             oe_,
    output tri logic [WIDTH-1:0] q,
    output logic             flag,
    output logic             ovr
);

    logic [WIDTH-1:0] data_q;
    logic             load;
    logic             clear;

    // NOTE: compare against 1'b0 so that an x/z control pin evaluates as
    // "not asserted" when used as an if-condition, rather than as a load.
    assign load  = (le_  == 1'b0);
    assign clear = (clr_ == 1'b0);

    // Data register: captures d on a load, otherwise holds.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others (ovr reads the old flag).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= d;
        end
    end

    // Handshake flag and sticky overrun. A clear is applied first, so a load
    // on the same edge still sets the flag but cannot raise the overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag <= 1'b0;
            ovr  <= 1'b0;
        end else if (load) begin
            flag <= 1'b1;
            if (clear) begin
                ovr <= 1'b0;
            end else begin
                ovr <= ovr | flag;
            end
        end else if (clear) begin
            flag <= 1'b0;
            ovr  <= 1'b0;
        end
    end

    // Output driver: combinational from the enable pin only, non-inverted
    // (the downstream bus driver performs the inversion).
    assign q = (oe_ == 1'b0) ? data_q : {WIDTH{1'bz}};

endmodule

// File: rtl/am2950_port.sv
// am2950_port: 8-bit bidirectional I/O port with handshake flags. Two
// independent channels: R carries a_in to b_out, S carries b_in to a_out.
module am2950_port #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cer_,
    input  logic             ces_,
    input  logic             clrr_,
    input  logic             clrs_,
    input  logic             oeb_,
    input  logic             oea_,
    output tri logic [WIDTH-1:0] b_out,
    output tri logic [WIDTH-1:0] a_out,
    output logic             fr,
    output logic             fs,
    output logic             ovr,
    output logic             ovs
);

    // Channel R: A side in, B side out.
    am2950_chan #(.WIDTH(WIDTH)) u_chan_r (
        .clk  (clk),
        .rst  (rst),
        .d    (a_in),
        .le_  (cer_),
        .clr_ (clrr_),
        .oe_  (oeb_),
        .q    (b_out),
        .flag (fr),
        .ovr  (ovr)
    );

    // Channel S: B side in, A side out.
    am2950_chan #(.WIDTH(WIDTH)) u_chan_s (
        .clk  (clk),
        .rst  (rst),
        .d    (b_in),
        .le_  (ces_),
        .clr_ (clrs_),
        .oe_  (oea_),
        .q    (a_out),
        .flag (fs),
        .ovr  (ovs)
    );

endmodule

// File: tb/tb_am2950_port.sv
// tb_am2950_port: directed scenarios plus randomized traffic, compared
// against a per-channel behavioural model. Outputs are observed on pulldown
// nets, so a released (hi-z) output reads as all zeros.
module tb_am2950_port;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_in, b_in;
    logic         cer_, ces_, clrr_, clrs_, oeb_, oea_;
    tri0  [W-1:0] b_out, a_out;
    logic         fr, fs, ovr, ovs;

    int errors = 0;
    int checks = 0;

    // Model state, index 0 = channel R, index 1 = channel S.
    logic [W-1:0] m_reg  [2];
    logic         m_flag [2];
    logic         m_ovr  [2];

    am2950_port #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .a_in  (a_in),
        .b_in  (b_in),
        .cer_  (cer_),
        .ces_  (ces_),
        .clrr_ (clrr_),
        .clrs_ (clrs_),
        .oeb_  (oeb_),
        .oea_  (oea_),
        .b_out (b_out),
        .a_out (a_out),
        .fr    (fr),
        .fs    (fs),
        .ovr   (ovr),
        .ovs   (ovs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_reg[c]  = '0;
            m_flag[c] = 1'b0;
            m_ovr[c]  = 1'b0;
        end
    endtask

    // One rising edge of the model, from the pin values at that edge.
    task automatic model_edge();
        logic         ld  [2];
        logic         cl  [2];
        logic [W-1:0] din [2];
        ld[0] = !cer_;  cl[0] = !clrr_; din[0] = a_in;
        ld[1] = !ces_;  cl[1] = !clrs_; din[1] = b_in;
        for (int c = 0; c < 2; c++) begin
            if (ld[c]) begin
                m_ovr[c]  = cl[c] ? 1'b0 : (m_ovr[c] | m_flag[c]);
                m_reg[c]  = din[c];
                m_flag[c] = 1'b1;
            end else if (cl[c]) begin
                m_flag[c] = 1'b0;
                m_ovr[c]  = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s.b_out", tag), 32'(b_out), 32'(oeb_ ? '0 : m_reg[0]));
        check($sformatf("%s.a_out", tag), 32'(a_out), 32'(oea_ ? '0 : m_reg[1]));
        check($sformatf("%s.fr", tag),    32'(fr),    32'(m_flag[0]));
        check($sformatf("%s.fs", tag),    32'(fs),    32'(m_flag[1]));
        check($sformatf("%s.ovr", tag),   32'(ovr),   32'(m_ovr[0]));
        check($sformatf("%s.ovs", tag),   32'(ovs),   32'(m_ovr[1]));
    endtask

    // Inputs are set just after a falling edge; this applies one rising edge
    // and returns at the next falling edge with outputs settled.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_pins();
        cer_ = 1'b1; ces_ = 1'b1; clrr_ = 1'b1; clrs_ = 1'b1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        a_in = '0; b_in = '0;
        oeb_ = 1'b0; oea_ = 1'b0;
        idle_pins();
        model_reset();

        // Reset mid-cycle with outputs enabled: zeros before any edge.
        @(negedge clk);
        pulse_reset("reset");
        check("reset.b_zero", 32'(b_out), 32'h00);
        check("reset.a_zero", 32'(a_out), 32'h00);

        // Handshake on R.
        oeb_ = 1'b1;
        a_in = 8'hA5; cer_ = 1'b0;
        tick();
        cer_ = 1'b1; oeb_ = 1'b0;
        #1;
        check("hs.data", 32'(b_out), 32'hA5);
        check("hs.fr", 32'(fr), 32'd1);
        check_all("hs.load");
        clrr_ = 1'b0;
        tick();
        clrr_ = 1'b1;
        check("hs.fr_clr", 32'(fr), 32'd0);
        check("hs.data_kept", 32'(b_out), 32'hA5);

        // Overrun on R.
        a_in = 8'h11; cer_ = 1'b0;
        tick();
        a_in = 8'h22;
        tick();
        cer_ = 1'b1;
        check("ovr.data", 32'(b_out), 32'h22);
        check("ovr.fr", 32'(fr), 32'd1);
        check("ovr.ovr", 32'(ovr), 32'd1);
        check_all("ovr");

        // Simultaneous load and clear with fr=1, ovr=1.
        a_in = 8'h3C; cer_ = 1'b0; clrr_ = 1'b0;
        tick();
        idle_pins();
        check("sim.data", 32'(b_out), 32'h3C);
        check("sim.fr", 32'(fr), 32'd1);
        check("sim.ovr", 32'(ovr), 32'd0);

        // Plain clear afterwards.
        clrr_ = 1'b0;
        tick();
        clrr_ = 1'b1;
        check_all("clr");

        // Independence and tri-state: R holds C3, S loaded with 5A.
        a_in = 8'hC3; cer_ = 1'b0;
        tick();
        cer_ = 1'b1;
        b_in = 8'h5A; ces_ = 1'b0; a_in = 8'h00;
        tick();
        ces_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            oea_ = i[0];
            oeb_ = ~i[0];
            #1;
            check($sformatf("tri.a_out%0d", i), 32'(a_out), i[0] ? 32'h00 : 32'h5A);
            check($sformatf("tri.b_out%0d", i), 32'(b_out), i[0] ? 32'hC3 : 32'h00);
            check($sformatf("tri.fr%0d", i), 32'(fr), 32'd1);
            check($sformatf("tri.ovr%0d", i), 32'(ovr), 32'd0);
        end
        oea_ = 1'b0; oeb_ = 1'b0;

        // Reset mid-operation: FF held, then discarded.
        a_in = 8'hFF; cer_ = 1'b0;
        tick();
        cer_ = 1'b1;
        check("rmid.pre", 32'(b_out), 32'hFF);
        pulse_reset("rmid");
        check("rmid.fr", 32'(fr), 32'd0);
        check("rmid.data", 32'(b_out), 32'h00);
        a_in = 8'h01; cer_ = 1'b0;
        tick();
        cer_ = 1'b1;
        check("rmid.fr_after", 32'(fr), 32'd1);
        check("rmid.ovr_after", 32'(ovr), 32'd0);
        check("rmid.data_after", 32'(b_out), 32'h01);

        // Randomized traffic on both channels.
        for (int n = 0; n < 400; n++) begin
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            cer_  = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
            ces_  = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
            clrr_ = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
            clrs_ = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
            oeb_  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            oea_  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            tick();
            check_all($sformatf("rnd%0d", n));
            if ($urandom_range(0, 49) == 0) begin
                idle_pins();
                pulse_reset($sformatf("rnd_rst%0d", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/am2950_port.md
AM2950_PORT -- requirements
Module: am2950_port

Interface
REQ-001 Parameter: WIDTH, default 8, data path width of both channels.
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a_in  input  WIDTH  A-side data into register R.
REQ-005 b_in  input  WIDTH  B-side data into register S.
REQ-006 cer_  input  1  active-low load enable, R <= a_in.
REQ-007 ces_  input  1  active-low load enable, S <= b_in.
REQ-008 clrr_  input  1  active-low synchronous clear of flag fr and overrun ovr.
REQ-009 clrs_  input  1  active-low synchronous clear of flag fs and overrun ovs.
REQ-010 oeb_  input  1  active-low output enable, b_out = R.
REQ-011 oea_  input  1  active-low output enable, a_out = S.
REQ-012 b_out  output  WIDTH  R contents, non-inverted; all-z when oeb_=1.
REQ-013 a_out  output  WIDTH  S contents, non-inverted; all-z when oea_=1.
REQ-014 fr, fs  output  1 each  "register full" handshake flags.
REQ-015 ovr, ovs  output  1 each  sticky overrun: load attempted while flag already set.

Function
REQ-016 Two independent identical channels: R (a_in->b_out, cer_/clrr_/oeb_, fr/ovr) and S (b_in->a_out, ces_/clrs_/oea_, fs/ovs); REQ-017..022 stated for R, apply identically to S.
REQ-018 Load only: cer_=0, clrr_=1 -> R<=a_in, fr<=1, ovr<=ovr|fr (old fr).
REQ-019 Clear only: cer_=1, clrr_=0 -> R held, fr<=0, ovr<=0.
REQ-020 Simultaneous load and clear: cer_=0, clrr_=0 -> R<=a_in, fr<=1, ovr<=0 (clear applies first, load wins).
REQ-021 Neither asserted: R, fr, ovr hold.
REQ-022 Latency: loaded data visible on b_out one cycle after the loading edge, with fr high at that same point; output enables combinational, zero latency, no effect on state.
REQ-023 Enables and clears are X-safe: any value other than 1'b0 on cer_/clrr_ treated as deasserted.
REQ-024 Output tri-state combinational from oe pins only; a_out/b_out never undriven-x when enabled after reset.
REQ-025 Channels fully independent: activity on one channel never changes the other channel's register, flag or overrun.

Reset
REQ-026 rst=1 forces immediately, regardless of clk: R=0, S=0, fr=fs=0, ovr=ovs=0.
REQ-027 Outputs during reset: a_out/b_out follow oe pins (0 if enabled, z if not).
REQ-028 rst asserted mid-operation (between load and clear) discards data and flags; first edge after rst deassertion obeys REQ-018..021 normally.

Structure
REQ-029 No shared package; WIDTH is the only constant, passed as a parameter.
REQ-030 One sub-module, am2950_chan (WIDTH parameter; clk, rst, d, le_, clr_, oe_, q, flag, ovr); am2950_port instantiates it twice.
REQ-031 b_out/a_out drive a downstream am2958-style inverting tristate driver; no inversion in this block.

Verification
REQ-032 Reset: rst=1 mid-cycle, oeb_=oea_=0 -> b_out=a_out=8'h00, fr=fs=ovr=ovs=0 immediately, before the next clk edge.
REQ-033 Handshake: a_in=8'hA5, cer_=0 one cycle, then oeb_=0 -> b_out=8'hA5, fr=1; clrr_=0 one cycle -> fr=0, b_out still 8'hA5.
REQ-034 Overrun: load 8'h11, then load 8'h22 without clear -> b_out=8'h22, fr=1, ovr=1; clrr_=0 -> ovr=0, fr=0.
REQ-035 Simultaneous: fr=1, ovr=1, then cer_=0 and clrr_=0 same edge with a_in=8'h3C -> R=8'h3C, fr=1, ovr=0.
REQ-036 Independence and tri-state: load S with 8'h5A via ces_ while R is holding 8'hC3; toggle oea_/oeb_ -> a_out alternates 8'h5A/z, b_out alternates 8'hC3/z; fr, ovr unchanged by S activity.
REQ-037 Reset mid-operation: fr=1 holding 8'hFF, pulse rst -> fr=0, R=0; next load of 8'h01 -> fr=1, ovr=0.
